instr_aligner: RTL and testbench
================================

Name: instr_aligner

Overview:
- Aligns fetched 32-bit words into complete RVI/RVC instructions, one per cycle, for the decoder.
- Sits between the fetch/predictor stage and the ID-stage decoder.
- Buffers one halfword so RVI instructions that straddle a word boundary are reassembled.
- Flags partial instructions broken by a redirect, so the decoder raises a discard misconduct.

Parameters:
- FETCH_VALID, 3'b000, fetch-error code meaning "no error"; taken from the shared package, not overridable per instance.

Ports:
- s_clk_i  in  1  clock
- s_rst_i  in  1  reset: asynchronous, active-high
- s_flush_i  in  1  pipeline flush/restart; drops buffer and output
- s_word_i  in  32  fetched word
- s_wvalid_i  in  1  s_word_i valid
- s_wready_o  out  1  aligner accepts s_word_i this cycle
- s_wupper_i  in  1  first useful halfword is [31:16] (redirect to PC[1]=1)
- s_wtarget_i  in  1  word is first after a predictor redirect
- s_wpred_i  in  1  prediction made on this word
- s_werror_i  in  3  fetch error code of this word
- s_stall_i  in  1  decoder cannot accept; hold outputs
- s_instr_o  out  32  aligned instruction; RVC in [15:0], [31:16]=0
- s_ivalid_o  out  1  s_instr_o valid
- s_pred_o  out  1  prediction flag of the word supplying the last halfword
- s_ferror_o  out  3  fetch error forwarded to the decoder
- s_aerror_o  out  1  alignment error

Behaviour:
- Reset: all outputs 0 (s_instr_o, s_ivalid_o, s_pred_o, s_ferror_o, s_aerror_o); state EMPTY; buffer 0.
- Outputs are registered. One-cycle latency from word acceptance to s_ivalid_o.
- s_stall_i=1 holds all outputs and state. A word is accepted only when s_wvalid_i & s_wready_o.
- Halfword h is RVC iff h[1:0]!=2'b11.
- Buffer holds hw[15:0] plus its error and pred bits.
- States:
  - EMPTY: no buffered halfword. s_wready_o = ~s_stall_i.
  - PART: buffer holds the low half of an RVI instruction. s_wready_o = ~s_stall_i.
  - FULLC: buffer holds a complete RVC instruction. s_wready_o = 0.
- EMPTY, word accepted, s_wupper_i=0:
  - low half RVI: emit the whole word; stay EMPTY.
  - low half RVC: emit the low half; buffer the upper half.
    - upper half RVC: go to FULLC.
    - upper half RVI: go to PART.
- EMPTY, word accepted, s_wupper_i=1:
  - upper half RVC: emit it; stay EMPTY.
  - upper half RVI: buffer it; go to PART; no output.
- PART, word accepted, s_wtarget_i=0:
  - emit {word[15:0], buffer}.
  - s_ferror_o = buffered error if it is not FETCH_VALID, else the new word's error.
  - s_pred_o = s_wpred_i.
  - Then process word[31:16] as in the EMPTY case: RVC goes to FULLC, RVI goes to PART.
- PART, word accepted, s_wtarget_i=1 (redirect mid-instruction):
  - emit {16'b0, buffer} with s_aerror_o=1.
  - Drop the new word's content; go to EMPTY. The decoder restarts fetch via discard.
- FULLC, ~s_stall_i: emit the buffered RVC with its error/pred; go to EMPTY.
- No accepted word and not FULLC: s_ivalid_o <= 0 (when not stalled).
- Error-word rules:
  - A word accepted with an error other than FETCH_VALID while in EMPTY is emitted as one instruction, with s_ivalid_o=1 and the error code.
  - Its halves are not buffered; state goes to EMPTY.
- s_flush_i (highest priority, overrides stall):
  - next cycle state EMPTY, s_ivalid_o=0, s_aerror_o=0.
  - A simultaneous word is dropped.
- Reset asserted mid-operation: immediate return to reset values.
- Width rules: RVC outputs are zero-extended to 32 bits. No arithmetic.

Decomposition:
- p_hardisc: the FETCH_VALID and FETCH_* error codes (already there); add the aligner state enum (ALN_EMPTY, ALN_PART, ALN_FULLC).
- No sub-module. An is_rvc check is inline and not worth a module.

Test Plan:
- Aligned RVI word 0x00500093, s_wupper_i=0 -> next cycle s_instr_o=0x00500093, s_ivalid_o=1, state EMPTY.
- Word 0x00014505 (RVC 0x4505, RVC 0x0001) -> cycle 1 s_instr_o=0x00004505; cycle 2 0x00000001 with s_wready_o=0 during FULLC.
- Word 0x00934505, then 0x00000050 -> cycle 1 0x00004505; cycle 2 0x00500093 (straddled RVI reassembled).
- PART, then next word with s_wtarget_i=1 -> s_aerror_o=1, s_instr_o[15:0]=buffered half, state EMPTY.
- Straddle where the first word had s_werror_i=3'b010 and the second 0 -> s_ferror_o=3'b010; s_stall_i=1 for 3 cycles holds outputs unchanged.
- s_flush_i in FULLC with s_wvalid_i=1 -> next cycle s_ivalid_o=0, state EMPTY, word dropped; s_rst_i pulse mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/p_hardisc.sv
// Shared definitions for the hardisc front end: fetch error codes, the
// aligner state encoding and the compressed-instruction test.
package p_hardisc;

    localparam logic [2:0] FETCH_VALID = 3'b000;
    localparam logic [2:0] FETCH_BSERR = 3'b001;
    localparam logic [2:0] FETCH_PMAER = 3'b010;
    localparam logic [2:0] FETCH_INCER = 3'b011;

    typedef enum logic [1:0] {
        ALN_EMPTY,
        ALN_PART,
        ALN_FULLC
    } aln_state_t;

    // A halfword starts an RVC instruction unless its two low bits are both set.
    function automatic logic is_rvc(input logic [15:0] hw);
        return hw[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/instr_aligner.sv
// Turns fetched 32-bit words into whole RVI/RVC instructions for the decoder,
// buffering one halfword so instructions crossing a word boundary are rebuilt.
module instr_aligner
    import p_hardisc::*;
(
    input  logic        s_clk_i,
    input  logic        s_rst_i,
    input  logic        s_flush_i,
    input  logic [31:0] s_word_i,
    input  logic        s_wvalid_i,
    output logic        s_wready_o,
    input  logic        s_wupper_i,
    input  logic        s_wtarget_i,
    input  logic        s_wpred_i,
    input  logic [2:0]  s_werror_i,
    input  logic        s_stall_i,
    output logic [31:0] s_instr_o,
    output logic        s_ivalid_o,
    output logic        s_pred_o,
    output logic [2:0]  s_ferror_o,
    output logic        s_aerror_o
);

    aln_state_t  state, state_n;
    logic [15:0] hold_hw, hold_hw_n;
    logic [2:0]  hold_err, hold_err_n;
    logic        hold_pred, hold_pred_n;
    logic [31:0] instr_q, instr_n;
    logic        ivalid_q, ivalid_n;
    logic        pred_q, pred_n;
    logic [2:0]  ferror_q, ferror_n;
    logic        aerror_q, aerror_n;
    logic        accept;
    logic [15:0] lo, hi;

    assign lo         = s_word_i[15:0];
    assign hi         = s_word_i[31:16];
    assign s_wready_o = ~s_stall_i & (state != ALN_FULLC);
    assign accept     = s_wvalid_i & s_wready_o;

    assign s_instr_o  = instr_q;
    assign s_ivalid_o = ivalid_q;
    assign s_pred_o   = pred_q;
    assign s_ferror_o = ferror_q;
    assign s_aerror_o = aerror_q;

    always_comb begin
        state_n     = state;
        hold_hw_n   = hold_hw;
        hold_err_n  = hold_err;
        hold_pred_n = hold_pred;
        instr_n     = instr_q;
        pred_n      = pred_q;
        ferror_n    = ferror_q;
        ivalid_n    = 1'b0;
        aerror_n    = 1'b0;

        if (s_flush_i) begin
            state_n     = ALN_EMPTY;
            hold_hw_n   = 16'h0;
            hold_err_n  = FETCH_VALID;
            hold_pred_n = 1'b0;
            instr_n     = 32'h0;
            pred_n      = 1'b0;
            ferror_n    = FETCH_VALID;
        end else if (s_stall_i) begin
            ivalid_n = ivalid_q;
            aerror_n = aerror_q;
        end else begin
            case (state)
                ALN_FULLC: begin
                    instr_n  = {16'h0, hold_hw};
                    ferror_n = hold_err;
                    pred_n   = hold_pred;
                    ivalid_n = 1'b1;
                    state_n  = ALN_EMPTY;
                end
                ALN_PART: begin
                    if (accept && s_wtarget_i) begin
                        // A redirect broke the instruction; hand over the orphan half flagged.
                        instr_n  = {16'h0, hold_hw};
                        ferror_n = hold_err;
                        pred_n   = hold_pred;
                        ivalid_n = 1'b1;
                        aerror_n = 1'b1;
                        state_n  = ALN_EMPTY;
                    end else if (accept) begin
                        instr_n     = {lo, hold_hw};
                        ferror_n    = (hold_err != FETCH_VALID) ? hold_err : s_werror_i;
                        pred_n      = s_wpred_i;
                        ivalid_n    = 1'b1;
                        hold_hw_n   = hi;
                        hold_err_n  = s_werror_i;
                        hold_pred_n = s_wpred_i;
                        state_n     = is_rvc(hi) ? ALN_FULLC : ALN_PART;
                    end
                end
                default: begin
                    if (accept) begin
                        ferror_n = s_werror_i;
                        pred_n   = s_wpred_i;
                        // Faulty words are never split; the decoder only needs the error.
                        if (s_werror_i != FETCH_VALID) begin
                            instr_n  = s_word_i;
                            ivalid_n = 1'b1;
                        end else if (s_wupper_i) begin
                            if (is_rvc(hi)) begin
                                instr_n  = {16'h0, hi};
                                ivalid_n = 1'b1;
                            end else begin
                                hold_hw_n   = hi;
                                hold_err_n  = s_werror_i;
                                hold_pred_n = s_wpred_i;
                                state_n     = ALN_PART;
                            end
                        end else if (!is_rvc(lo)) begin
                            instr_n  = s_word_i;
                            ivalid_n = 1'b1;
                        end else begin
                            instr_n     = {16'h0, lo};
                            ivalid_n    = 1'b1;
                            hold_hw_n   = hi;
                            hold_err_n  = s_werror_i;
                            hold_pred_n = s_wpred_i;
                            state_n     = is_rvc(hi) ? ALN_FULLC : ALN_PART;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge s_clk_i or posedge s_rst_i) begin
        if (s_rst_i) begin
            state     <= ALN_EMPTY;
            hold_hw   <= 16'h0;
            hold_err  <= FETCH_VALID;
            hold_pred <= 1'b0;
            instr_q   <= 32'h0;
            ivalid_q  <= 1'b0;
            pred_q    <= 1'b0;
            ferror_q  <= FETCH_VALID;
            aerror_q  <= 1'b0;
        end else begin
            state     <= state_n;
            hold_hw   <= hold_hw_n;
            hold_err  <= hold_err_n;
            hold_pred <= hold_pred_n;
            instr_q   <= instr_n;
            ivalid_q  <= ivalid_n;
            pred_q    <= pred_n;
            ferror_q  <= ferror_n;
            aerror_q  <= aerror_n;
        end
    end

endmodule

// File: tb/tb_instr_aligner.sv
// Testbench for instr_aligner: directed scenarios followed by a randomized run
// checked against a halfword-queue reference model.
module tb_instr_aligner;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] word = 32'h0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic        wupper = 1'b0;
    logic        wtarget = 1'b0;
    logic        wpred = 1'b0;
    logic [2:0]  werror = 3'b000;
    logic        stall = 1'b0;
    logic [31:0] instr;
    logic        ivalid;
    logic        pred;
    logic [2:0]  ferror;
    logic        aerror;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [15:0] hw;
        logic [2:0]  err;
        logic        pred;
    } half_t;

    half_t q[$];

    instr_aligner dut (
        .s_clk_i     (clk),
        .s_rst_i     (rst),
        .s_flush_i   (flush),
        .s_word_i    (word),
        .s_wvalid_i  (wvalid),
        .s_wready_o  (wready),
        .s_wupper_i  (wupper),
        .s_wtarget_i (wtarget),
        .s_wpred_i   (wpred),
        .s_werror_i  (werror),
        .s_stall_i   (stall),
        .s_instr_o   (instr),
        .s_ivalid_o  (ivalid),
        .s_pred_o    (pred),
        .s_ferror_o  (ferror),
        .s_aerror_o  (aerror)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [31:0] w, input logic up, input logic tg,
                         input logic pr, input logic [2:0] er, input logic st, input logic fl);
        wvalid  = v;
        word    = w;
        wupper  = up;
        wtarget = tg;
        wpred   = pr;
        werror  = er;
        stall   = st;
        flush   = fl;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        checks++;
        if ({ivalid, aerror, ferror, pred, instr} !== 38'h0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got v=%b a=%b e=%b p=%b i=%h, expected all zero",
                     ivalid, aerror, ferror, pred, instr);
        end
        checks++;
        if (wready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_wready: got %b expected 1", wready);
        end
    endtask

    task automatic test_aligned_rvi;
        drive(1, 32'h00500093, 0, 0, 0, 3'b000, 0, 0);
        tick();
        checks++;
        if ({ivalid, aerror, ferror, instr} !== {1'b1, 1'b0, 3'b000, 32'h00500093}) begin
            errors++;
            $display("[TB] FAIL aligned_rvi: got v=%b a=%b e=%b i=%h expected v=1 a=0 e=0 i=00500093",
                     ivalid, aerror, ferror, instr);
        end
        checks++;
        if (wready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL aligned_rvi_ready: got %b expected 1", wready);
        end
        drive(0, 32'h0, 0, 0, 0, 3'b000, 0, 0);
        tick();
        checks++;
        if (ivalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL aligned_rvi_idle: ivalid got %b expected 0", ivalid);
        end
    endtask

    task automatic test_rvc_pair;
        drive(1, 32'h00014505, 0, 0, 1, 3'b000, 0, 0);
        tick();
        checks++;
        if ({ivalid, pred, instr} !== {1'b1, 1'b1, 32'h00004505}) begin
            errors++;
            $display("[TB] FAIL rvc_first: got v=%b p=%b i=%h expected v=1 p=1 i=00004505", ivalid, pred, instr);
        end
        checks++;
        if (wready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rvc_fullc_ready: got %b expected 0", wready);
        end
        drive(1, 32'hDEADBEEF, 0, 0, 0, 3'b000, 0, 0);
        tick();
        checks++;
        if ({ivalid, pred, instr} !== {1'b1, 1'b1, 32'h00000001}) begin
            errors++;
            $display("[TB] FAIL rvc_second: got v=%b p=%b i=%h expected v=1 p=1 i=00000001", ivalid, pred, instr);
        end
        drive(0, 32'h0, 0, 0, 0, 3'b000, 0, 0);
        tick();
        checks++;
        if (ivalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rvc_refused_word: ivalid got %b expected 0", ivalid);
        end
    endtask

    task automatic test_straddle;
        drive(1, 32'h00934505, 0, 0, 0, 3'b000, 0, 0);
        tick();
        checks++;
        if ({ivalid, instr} !== {1'b1, 32'h00004505}) begin
            errors++;
            $display("[TB] FAIL straddle_first: got v=%b i=%h expected v=1 i=00004505", ivalid, instr);
        end
        drive(1, 32'h00000050, 0, 0, 1, 3'b000, 0, 0);
        tick();
        checks++;
        if ({ivalid, pred, ferror, instr} !== {1'b1, 1'b1, 3'b000, 32'h00500093}) begin
            errors++;
            $display("[TB] FAIL straddle_join: got v=%b p=%b e=%b i=%h expected v=1 p=1 e=0 i=00500093",
                     ivalid, pred, ferror, instr);
        end
        checks++;
        if (wready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL straddle_tail_ready: got %b expected 0", wready);
        end
        drive(0, 32'h0, 0, 0, 0, 3'b000, 0, 0);
        tick();
        checks++;
        if ({ivalid, instr} !== {1'b1, 32'h00000000}) begin
            errors++;
            $display("[TB] FAIL straddle_tail: got v=%b i=%h expected v=1 i=00000000", ivalid, instr);
        end
        tick();
        checks++;
        if (ivalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL straddle_idle: ivalid got %b expected 0", ivalid);
        end
    endtask

    task automatic test_redirect;
        drive(1, 32'h00930001, 0, 0, 0, 3'b000, 0, 0);
        tick();
        checks++;
        if ({ivalid, instr} !== {1'b1, 32'h00000001}) begin
            errors++;
            $display("[TB] FAIL redirect_setup: got v=%b i=%h expected v=1 i=00000001", ivalid, instr);
        end
        drive(1, 32'h12345678, 0, 1, 0, 3'b000, 0, 0);
        tick();
        checks++;
        if ({ivalid, aerror, instr[15:0]} !== {1'b1, 1'b1, 16'h0093}) begin
            errors++;
            $display("[TB] FAIL redirect_aerror: got v=%b a=%b i=%h expected v=1 a=1 i[15:0]=0093",
                     ivalid, aerror, instr);
        end
        drive(0, 32'h0, 0, 0, 0, 3'b000, 0, 0);
        tick();
        checks++;
        if ({ivalid, wready} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL redirect_drop: got v=%b r=%b expected v=0 r=1", ivalid, wready);
        end
    endtask

    task automatic test_error_stall;
        logic [37:0] snap;
        drive(1, 32'h00930001, 0, 0, 0, 3'b000, 0, 0);
        tick();
        drive(1, 32'h00930050, 0, 0, 0, 3'b010, 0, 0);
        tick();
        checks++;
        if ({ivalid, ferror, instr} !== {1'b1, 3'b010, 32'h00500093}) begin
            errors++;
            $display("[TB] FAIL err_new_word: got v=%b e=%b i=%h expected v=1 e=010 i=00500093", ivalid, ferror, instr);
        end
        drive(1, 32'h00010050, 0, 0, 0, 3'b000, 0, 0);
        tick();
        checks++;
        if ({ivalid, ferror, instr} !== {1'b1, 3'b010, 32'h00500093}) begin
            errors++;
            $display("[TB] FAIL err_buffered: got v=%b e=%b i=%h expected v=1 e=010 i=00500093", ivalid, ferror, instr);
        end
        snap = {1'b1, 1'b0, 3'b010, 1'b0, 32'h00500093};
        drive(1, 32'h11111111, 0, 0, 0, 3'b000, 1, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({ivalid, aerror, ferror, pred, instr} !== snap || wready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL stall_hold[%0d]: got v=%b a=%b e=%b p=%b i=%h r=%b expected v=1 a=0 e=010 p=0 i=00500093 r=0",
                         k, ivalid, aerror, ferror, pred, instr, wready);
            end
        end
        drive(0, 32'h0, 0, 0, 0, 3'b000, 0, 0);
        tick();
        checks++;
        if ({ivalid, ferror, instr} !== {1'b1, 3'b000, 32'h00000001}) begin
            errors++;
            $display("[TB] FAIL stall_release: got v=%b e=%b i=%h expected v=1 e=0 i=00000001", ivalid, ferror, instr);
        end
        tick();
    endtask

    task automatic test_error_word;
        drive(1, 32'h00014505, 0, 0, 1, 3'b001, 0, 0);
        tick();
        checks++;
        if ({ivalid, ferror, pred, instr, wready} !== {1'b1, 3'b001, 1'b1, 32'h00014505, 1'b1}) begin
            errors++;
            $display("[TB] FAIL error_word: got v=%b e=%b p=%b i=%h r=%b expected v=1 e=001 p=1 i=00014505 r=1",
                     ivalid, ferror, pred, instr, wready);
        end
        drive(0, 32'h0, 0, 0, 0, 3'b000, 0, 0);
        tick();
        checks++;
        if (ivalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL error_word_unsplit: ivalid got %b expected 0", ivalid);
        end
    endtask

    task automatic test_flush_reset;
        drive(1, 32'h00014505, 0, 0, 0, 3'b000, 0, 0);
        tick();
        drive(1, 32'h00500093, 0, 0, 0, 3'b000, 0, 1);
        tick();
        checks++;
        if ({ivalid, aerror, wready} !== 3'b001) begin
            errors++;
            $display("[TB] FAIL flush_fullc: got v=%b a=%b r=%b expected v=0 a=0 r=1", ivalid, aerror, wready);
        end
        drive(0, 32'h0, 0, 0, 0, 3'b000, 0, 0);
        tick();
        checks++;
        if (ivalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_dropped: ivalid got %b expected 0", ivalid);
        end
        drive(1, 32'h00500093, 0, 0, 1, 3'b000, 0, 0);
        tick();
        drive(0, 32'h0, 0, 0, 0, 3'b000, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({ivalid, aerror, ferror, pred, instr} !== 38'h0) begin
            errors++;
            $display("[TB] FAIL reset_midstream: got v=%b a=%b e=%b p=%b i=%h expected all zero",
                     ivalid, aerror, ferror, pred, instr);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_random;
        logic        v, up, tg, pr, st, fl, acc, ready_m;
        logic [2:0]  er;
        logic [15:0] a, b;
        logic [31:0] e_instr;
        logic        e_valid, e_pred, e_aerr;
        logic [2:0]  e_ferr;
        half_t       h;
        e_instr = 32'h0; e_valid = 1'b0; e_pred = 1'b0; e_aerr = 1'b0; e_ferr = 3'b000;
        q.delete();
        for (int n = 0; n < 3000; n++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b11;
            if ($urandom_range(0, 1) == 1) b[1:0] = 2'b11;
            v  = ($urandom_range(0, 3) != 0);
            up = ($urandom_range(0, 6) == 0);
            tg = ($urandom_range(0, 9) == 0);
            pr = 1'($urandom);
            er = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            st = ($urandom_range(0, 4) == 0);
            fl = ($urandom_range(0, 29) == 0);
            drive(v, {b, a}, up, tg, pr, er, st, fl);
            #1;
            ready_m = !st && !(q.size() == 1 && q[0].hw[1:0] != 2'b11);
            checks++;
            if (wready !== ready_m) begin
                errors++;
                $display("[TB] FAIL rand_wready[%0d]: got %b expected %b", n, wready, ready_m);
            end
            acc = v && ready_m;
            if (fl) begin
                q.delete();
                e_valid = 1'b0; e_aerr = 1'b0;
            end else if (!st) begin
                e_valid = 1'b0;
                e_aerr  = 1'b0;
                if (q.size() == 1 && q[0].hw[1:0] != 2'b11) begin
                    e_valid = 1'b1; e_instr = {16'h0, q[0].hw}; e_ferr = q[0].err; e_pred = q[0].pred;
                    q.delete();
                end else if (acc) begin
                    if (q.size() == 0 && er != 3'b000) begin
                        e_valid = 1'b1; e_instr = {b, a}; e_ferr = er; e_pred = pr;
                    end else if (q.size() == 1 && tg) begin
                        e_valid = 1'b1; e_aerr = 1'b1;
                        e_instr = {16'h0, q[0].hw}; e_ferr = q[0].err; e_pred = q[0].pred;
                        q.delete();
                    end else begin
                        if (!(q.size() == 0 && up)) q.push_back({a, er, pr});
                        q.push_back({b, er, pr});
                        if (q[0].hw[1:0] != 2'b11) begin
                            h = q.pop_front();
                            e_valid = 1'b1; e_instr = {16'h0, h.hw}; e_ferr = h.err; e_pred = h.pred;
                        end else if (q.size() >= 2) begin
                            e_valid = 1'b1;
                            e_instr = {q[1].hw, q[0].hw};
                            e_ferr  = (q[0].err != 3'b000) ? q[0].err : q[1].err;
                            e_pred  = q[1].pred;
                            void'(q.pop_front());
                            void'(q.pop_front());
                        end
                    end
                end
            end
            @(posedge clk);
            #1;
            checks++;
            if (ivalid !== e_valid) begin
                errors++;
                $display("[TB] FAIL rand_ivalid[%0d]: got %b expected %b", n, ivalid, e_valid);
            end else if (e_valid) begin
                checks++;
                if ({aerror, ferror, pred, instr} !== {e_aerr, e_ferr, e_pred, e_instr}) begin
                    errors++;
                    $display("[TB] FAIL rand_instr[%0d]: got a=%b e=%b p=%b i=%h expected a=%b e=%b p=%b i=%h",
                             n, aerror, ferror, pred, instr, e_aerr, e_ferr, e_pred, e_instr);
                end
            end
        end
        drive(0, 32'h0, 0, 0, 0, 3'b000, 0, 0);
    endtask

    initial begin
        #2;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        test_aligned_rvi();
        test_rvc_pair();
        test_straddle();
        test_redirect();
        test_error_stall();
        test_error_word();
        test_flush_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
